// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter and its DataPath integration.
// Holds memory command encodings, arbiter FSM state/owner enums and request/response bundles.
// No logic lives here apart from a tiny pending-request helper.
package mem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_TYP_W  = 3;

  // Memory function: read or write.
  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } MemoryWriteSignal;

  // Access size / sign-extension type carried with each request.
  typedef enum logic [ARB_TYP_W-1:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_D  = 3'd4,
    MT_BU = 3'd5,
    MT_HU = 3'd6,
    MT_WU = 3'd7
  } MemoryMaskType;

  // Arbiter FSM: at most one transaction outstanding on the backing memory.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } ArbState;

  // Which core port owns the in-flight transaction.
  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } ArbOwner;

  // Request bundle as presented to the backing memory.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
    MemoryWriteSignal      fcn;
    MemoryMaskType         typ;
  } MemArbReq;

  // Response bundle as returned to a core port.
  typedef struct packed {
    logic                  vld;
    logic [ARB_DATA_W-1:0] data;
  } MemArbResp;

  // A port still needs service this pipeline step when it asks and has not been answered.
  function automatic logic arb_pending(input logic req_vld, input logic done);
    return req_vld & ~done;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported backing memory between the core's imem and dmem ports.
// Latency: grant the cycle after a request is seen, response visible 1 cycle after mem_resp_valid.
// Backpressure: holds request fields while mem_req_ready is low; stalls the core via cmiss_stall.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TYP_W  = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              imem_req_valid,
  input  logic [ADDR_W-1:0] imem_req_addr,
  output logic              imem_resp_valid,
  output logic [DATA_W-1:0] imem_resp_data,

  input  logic              dmem_req_valid,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic [DATA_W-1:0] dmem_req_data,
  input  logic              dmem_req_fcn,
  input  logic [TYP_W-1:0]  dmem_req_typ,
  output logic              dmem_resp_valid,
  output logic [DATA_W-1:0] dmem_resp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_fcn,
  output logic [TYP_W-1:0]  mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,

  output logic              cmiss_stall
);

  // FSM state and the port owning the outstanding transaction.
  ArbState           state_q;
  ArbOwner           owner_q;

  // Registered request presented to the backing memory.
  logic              req_vld_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;
  logic              req_fcn_q;
  logic [TYP_W-1:0]  req_typ_q;

  // Per-port "served this pipeline step" flags and captured response data.
  logic              done_imem_q;
  logic              done_dmem_q;
  logic [DATA_W-1:0] resp_dat_imem_q;
  logic [DATA_W-1:0] resp_dat_dmem_q;

  logic              pend_imem;
  logic              pend_dmem;

  // Outstanding work for the current pipeline step decides whether the core must freeze.
  always_comb begin
    pend_imem = arb_pending(imem_req_valid, done_imem_q);
    pend_dmem = arb_pending(dmem_req_valid, done_dmem_q);
  end

  assign cmiss_stall     = pend_imem | pend_dmem;

  assign mem_req_valid   = req_vld_q;
  assign mem_req_addr    = req_addr_q;
  assign mem_req_data    = req_data_q;
  assign mem_req_fcn     = req_fcn_q;
  assign mem_req_typ     = req_typ_q;

  assign imem_resp_valid = done_imem_q;
  assign imem_resp_data  = resp_dat_imem_q;
  assign dmem_resp_valid = done_dmem_q;
  assign dmem_resp_data  = resp_dat_dmem_q;

  // Arbiter FSM with registered request fields, done flags and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ARB_IDLE;
      owner_q         <= OWN_IMEM;
      req_vld_q       <= 1'b0;
      req_addr_q      <= '0;
      req_data_q      <= '0;
      req_fcn_q       <= 1'b0;
      req_typ_q       <= '0;
      done_imem_q     <= 1'b0;
      done_dmem_q     <= 1'b0;
      resp_dat_imem_q <= '0;
      resp_dat_dmem_q <= '0;
    end else begin
      // The pipeline advances on a stall-free cycle, so every port starts the next step unserved.
      // A completion in the same cycle (killed requester) overrides this below.
      if (!cmiss_stall) begin
        done_imem_q <= 1'b0;
        done_dmem_q <= 1'b0;
      end

      case (state_q)
        ARB_IDLE: begin
          // dmem first: it belongs to the older instruction in the pipeline.
          if (pend_dmem) begin
            owner_q    <= OWN_DMEM;
            req_vld_q  <= 1'b1;
            req_addr_q <= dmem_req_addr;
            req_data_q <= dmem_req_data;
            req_fcn_q  <= dmem_req_fcn;
            req_typ_q  <= dmem_req_typ;
            state_q    <= ARB_REQ;
          end else if (pend_imem) begin
            owner_q    <= OWN_IMEM;
            req_vld_q  <= 1'b1;
            req_addr_q <= imem_req_addr;
            req_data_q <= '0;
            req_fcn_q  <= M_XRD;
            req_typ_q  <= '0;
            state_q    <= ARB_REQ;
          end
        end

        ARB_REQ: begin
          // Fields stay frozen until the memory takes them; responses here are spurious.
          if (mem_req_ready) begin
            req_vld_q <= 1'b0;
            state_q   <= ARB_WAIT;
          end
        end

        ARB_WAIT: begin
          // Only one transaction is in flight, so any response now belongs to owner_q.
          // No regrant this cycle; IDLE picks the next requester one cycle later.
          if (mem_resp_valid) begin
            if (owner_q == OWN_DMEM) begin
              done_dmem_q     <= 1'b1;
              resp_dat_dmem_q <= mem_resp_data;
            end else begin
              done_imem_q     <= 1'b1;
              resp_dat_imem_q <= mem_resp_data;
            end
            state_q <= ARB_IDLE;
          end
        end

        default: begin
          req_vld_q <= 1'b0;
          state_q   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
